// File: rtl/apb_master9_pkg.sv
// Shared types and widths for the apb_subsystem9 APB3 initiator.
// The APB_MST_TIMEOUT_EN build option uses TIMEOUT_CYC_DFLT as its default abort limit.
package apb_mst_pkg9;

    localparam int APB_ADDR_W       = 8;
    localparam int APB_DATA_W       = 32;
    localparam int TIMEOUT_CYC_DFLT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

endpackage

// File: rtl/apb_master9_if.sv
// Request/response port and APB3 bus signals of apb_master9.
// The mst modport is the initiator's view; slv is the bridge/peripheral side.
interface apb_master9_if
    import apb_mst_pkg9::*;
#(
    parameter int NUM_SLV = 4,
    parameter int SEL_W   = 2
);
    logic                  req_valid9;
    logic                  req_ready9;
    logic                  req_write9;
    logic [SEL_W-1:0]      req_sel9;
    logic [APB_ADDR_W-1:0] req_addr9;
    logic [APB_DATA_W-1:0] req_wdata9;

    logic                  rsp_valid9;
    logic [APB_DATA_W-1:0] rsp_rdata9;
    logic                  rsp_err9;

    logic [NUM_SLV-1:0]    psel9;
    logic                  penable9;
    logic                  pwrite9;
    logic [APB_ADDR_W-1:0] paddr9;
    logic [APB_DATA_W-1:0] pwdata9;
    logic [APB_DATA_W-1:0] prdata9;
    logic                  pready9;
    logic                  pslverr9;

    modport mst (
        input  req_valid9, req_write9, req_sel9, req_addr9, req_wdata9,
        output req_ready9,
        output rsp_valid9, rsp_rdata9, rsp_err9,
        output psel9, penable9, pwrite9, paddr9, pwdata9,
        input  prdata9, pready9, pslverr9
    );

    modport slv (
        output req_valid9, req_write9, req_sel9, req_addr9, req_wdata9,
        input  req_ready9,
        input  rsp_valid9, rsp_rdata9, rsp_err9,
        input  psel9, penable9, pwrite9, paddr9, pwdata9,
        output prdata9, pready9, pslverr9
    );

endinterface

// File: rtl/apb_master9_tmo_cnt.sv
// ACCESS-phase wait counter for apb_master9; only built with APB_MST_TIMEOUT_EN.
// expired_o flags the edge on which the count reaches TIMEOUT_CYC.
`ifdef APB_MST_TIMEOUT_EN
module apb_mst_tmo_cnt9
    import apb_mst_pkg9::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DFLT
) (
    input  logic pclk9,
    input  logic n_p_reset9,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge pclk9) begin
        if (!n_p_reset9) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = inc_i && (cnt_q == LAST_CNT);

endmodule
`endif

// File: rtl/apb_master9.sv
// APB3 initiator: one outstanding valid/ready request in, SETUP/ACCESS transfer out.
// Define APB_MST_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT_CYC cycles.
//
//   state  | meaning
//   IDLE   | ready for a request; psel9/penable9 low
//   SETUP  | psel9 asserted, penable9 low, one cycle
//   ACCESS | psel9 and penable9 high, waiting for pready9
module apb_master9
    import apb_mst_pkg9::*;
#(
    parameter int NUM_SLV     = 4,
    parameter int SEL_W       = 2,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DFLT
) (
    input  logic       pclk9,
    input  logic       n_p_reset9,
    apb_master9_if.mst bus
);
    localparam logic [SEL_W:0] NUM_SLV_W = (SEL_W + 1)'(NUM_SLV);

    if ((2 ** SEL_W) < NUM_SLV || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("apb_master9: SEL_W too narrow for NUM_SLV or TIMEOUT_CYC < 1");
    end

    apb_state_e            state_q;
    logic [NUM_SLV-1:0]    psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [APB_ADDR_W-1:0] paddr_q;
    logic [APB_DATA_W-1:0] pwdata_q;
    logic                  rsp_valid_q;
    logic [APB_DATA_W-1:0] rsp_rdata_q;
    logic                  rsp_err_q;

    logic                  req_ready;
    logic                  accept;
    logic                  sel_ok;
    logic [NUM_SLV-1:0]    psel_dec;
    logic                  tmo_abort;

    // Ready comes from state only, so the bridge sees no valid->ready loop.
    assign req_ready = (state_q == IDLE) && n_p_reset9;
    assign accept    = req_ready && bus.req_valid9;

    always_comb begin
        sel_ok   = ({1'b0, bus.req_sel9} < NUM_SLV_W);
        psel_dec = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            psel_dec[i] = (bus.req_sel9 == SEL_W'(i));
        end
    end

`ifdef APB_MST_TIMEOUT_EN
    apb_mst_tmo_cnt9 #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tmo_cnt (
        .pclk9      (pclk9),
        .n_p_reset9 (n_p_reset9),
        .clr_i      (accept && sel_ok),
        .inc_i      ((state_q == ACCESS) && !bus.pready9),
        .expired_o  (tmo_abort)
    );
`else
    assign tmo_abort = 1'b0;
`endif

    always_ff @(posedge pclk9) begin
        if (!n_p_reset9) begin
            state_q     <= IDLE;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (sel_ok) begin
                            state_q  <= SETUP;
                            psel_q   <= psel_dec;
                            pwrite_q <= bus.req_write9;
                            paddr_q  <= bus.req_addr9;
                            pwdata_q <= bus.req_write9 ? bus.req_wdata9 : '0;
                        end else begin
                            // Unknown slave: answer with an error, no bus cycle.
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                end
                ACCESS: begin
                    if (bus.pready9) begin
                        state_q     <= IDLE;
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= bus.pslverr9;
                        rsp_rdata_q <= (!pwrite_q && !bus.pslverr9) ? bus.prdata9 : '0;
                    end else if (tmo_abort) begin
                        state_q     <= IDLE;
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    psel_q    <= '0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready9 = req_ready;
    assign bus.rsp_valid9 = rsp_valid_q;
    assign bus.rsp_rdata9 = rsp_rdata_q;
    assign bus.rsp_err9   = rsp_err_q;
    assign bus.psel9      = psel_q;
    assign bus.penable9   = penable_q;
    assign bus.pwrite9    = pwrite_q;
    assign bus.paddr9     = paddr_q;
    assign bus.pwdata9    = pwdata_q;

endmodule

// File: tb/tb_apb_master9.sv
// Self-checking bench for apb_master9 (3 slaves, so select 3 is out of range).
// Expected bus/response behaviour is derived per transaction from the APB3 rules.
module tb_apb_master9;
    import apb_mst_pkg9::*;

    localparam int NSLV = 3;
    localparam int TMO  = 16;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    apb_master9_if #(.NUM_SLV(NSLV), .SEL_W(2)) bif ();

    apb_master9 #(
        .NUM_SLV     (NSLV),
        .SEL_W       (2),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .pclk9      (clk),
        .n_p_reset9 (rst_n),
        .bus        (bif.mst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_psel"},    32'(bif.psel9), 32'd0);
        check_val({tag, "_penable"}, 32'(bif.penable9), 32'd0);
        check_val({tag, "_pwrite"},  32'(bif.pwrite9), 32'd0);
        check_val({tag, "_paddr"},   32'(bif.paddr9), 32'd0);
        check_val({tag, "_pwdata"},  bif.pwdata9, 32'd0);
        check_val({tag, "_rvalid"},  32'(bif.rsp_valid9), 32'd0);
        check_val({tag, "_rdata"},   bif.rsp_rdata9, 32'd0);
        check_val({tag, "_rerr"},    32'(bif.rsp_err9), 32'd0);
        check_val({tag, "_ready"},   32'(bif.req_ready9), 32'd0);
    endtask

    // One request end to end; w = wait states, abort = expect a timeout instead.
    task automatic do_txn(input logic wr, input logic [1:0] sel, input logic [7:0] addr,
                          input logic [31:0] wdata, input int w, input logic serr,
                          input logic [31:0] rdata, input logic abort);
        logic        bad;
        logic [31:0] exp_psel;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          n;
        bad      = (int'(sel) >= NSLV);
        exp_psel = bad ? 32'd0 : (32'd1 << sel);
        exp_wd   = wr ? wdata : 32'd0;
        exp_err  = bad || abort || serr;
        exp_rd   = (wr || exp_err) ? 32'd0 : rdata;
        n        = abort ? TMO : w + 1;

        check_val("idle_ready", 32'(bif.req_ready9), 32'd1);
        bif.req_valid9 = 1'b1;
        bif.req_write9 = wr;
        bif.req_sel9   = sel;
        bif.req_addr9  = addr;
        bif.req_wdata9 = wdata;
        @(posedge clk);
        @(negedge clk);
        bif.req_valid9 = 1'b0;
        bif.req_write9 = 1'($urandom);
        bif.req_addr9  = 8'($urandom);
        bif.req_wdata9 = $urandom;

        if (!bad) begin
            check_val("setup_psel",    32'(bif.psel9), exp_psel);
            check_val("setup_penable", 32'(bif.penable9), 32'd0);
            check_val("setup_paddr",   32'(bif.paddr9), 32'(addr));
            check_val("setup_pwrite",  32'(bif.pwrite9), 32'(wr));
            check_val("setup_pwdata",  bif.pwdata9, exp_wd);
            check_val("setup_ready",   32'(bif.req_ready9), 32'd0);
            bif.pready9  = 1'($urandom);
            bif.pslverr9 = 1'($urandom);
            bif.prdata9  = $urandom;
            for (int i = 0; i < n; i++) begin
                @(posedge clk);
                @(negedge clk);
                check_val("acc_psel",    32'(bif.psel9), exp_psel);
                check_val("acc_penable", 32'(bif.penable9), 32'd1);
                check_val("acc_paddr",   32'(bif.paddr9), 32'(addr));
                check_val("acc_pwrite",  32'(bif.pwrite9), 32'(wr));
                check_val("acc_pwdata",  bif.pwdata9, exp_wd);
                check_val("acc_rvalid",  32'(bif.rsp_valid9), 32'd0);
                bif.pready9  = !abort && (i == w);
                bif.pslverr9 = (i == w) ? serr : 1'($urandom);
                bif.prdata9  = (i == w) ? rdata : $urandom;
            end
            @(posedge clk);
            @(negedge clk);
        end

        check_val("rsp_valid",   32'(bif.rsp_valid9), 32'd1);
        check_val("rsp_err",     32'(bif.rsp_err9), 32'(exp_err));
        check_val("rsp_rdata",   bif.rsp_rdata9, exp_rd);
        check_val("rsp_psel",    32'(bif.psel9), 32'd0);
        check_val("rsp_penable", 32'(bif.penable9), 32'd0);
        check_val("rsp_ready",   32'(bif.req_ready9), 32'd1);
        bif.pready9  = 1'($urandom);
        bif.pslverr9 = 1'($urandom);
        bif.prdata9  = $urandom;
        @(posedge clk);
        @(negedge clk);
        check_val("post_rvalid", 32'(bif.rsp_valid9), 32'd0);
        check_val("post_psel",   32'(bif.psel9), 32'd0);
        if (!bad) begin
            check_val("hold_paddr",  32'(bif.paddr9), 32'(addr));
            check_val("hold_pwrite", 32'(bif.pwrite9), 32'(wr));
        end
    endtask

    task automatic reset_mid_transfer();
        check_val("rst_ready_pre", 32'(bif.req_ready9), 32'd1);
        bif.req_valid9 = 1'b1;
        bif.req_write9 = 1'b0;
        bif.req_sel9   = 2'd2;
        bif.req_addr9  = 8'h44;
        bif.req_wdata9 = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        bif.req_valid9 = 1'b0;
        bif.pready9    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("rst_acc1_penable", 32'(bif.penable9), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check_val("rst_acc2_psel", 32'(bif.psel9), 32'd4);
        rst_n        = 1'b0;
        bif.pready9  = 1'b1;
        bif.prdata9  = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("rst_mid");
        rst_n       = 1'b1;
        bif.pready9 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("rst_rel_ready",  32'(bif.req_ready9), 32'd1);
        check_val("rst_rel_rvalid", 32'(bif.rsp_valid9), 32'd0);
        check_val("rst_rel_psel",   32'(bif.psel9), 32'd0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bif.req_valid9 = 1'b0;
        bif.req_write9 = 1'b0;
        bif.req_sel9   = '0;
        bif.req_addr9  = '0;
        bif.req_wdata9 = '0;
        bif.prdata9    = '0;
        bif.pready9    = 1'b0;
        bif.pslverr9   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);

        do_txn(1'b1, 2'd1, 8'h0C, 32'hA5A5_0001, 0, 1'b0, 32'h0, 1'b0);
        do_txn(1'b0, 2'd0, 8'h10, 32'h0,         3, 1'b0, 32'h0000_00FF, 1'b0);
        do_txn(1'b0, 2'd2, 8'h20, 32'h0,         1, 1'b1, 32'hDEAD_BEEF, 1'b0);
        do_txn(1'b0, 2'd3, 8'h30, 32'h0,         0, 1'b0, 32'h0, 1'b0);
        do_txn(1'b1, 2'd3, 8'h34, 32'h1111_2222, 0, 1'b0, 32'h0, 1'b0);
        reset_mid_transfer();
        do_txn(1'b0, 2'd1, 8'h50, 32'h0, TMO - 1, 1'b0, 32'h0BAD_CAFE, 1'b0);
`ifdef APB_MST_TIMEOUT_EN
        do_txn(1'b0, 2'd0, 8'h54, 32'h0, 0, 1'b0, 32'h0, 1'b1);
        do_txn(1'b1, 2'd2, 8'h58, 32'h7777_8888, TMO - 1, 1'b0, 32'h0, 1'b0);
`else
        do_txn(1'b0, 2'd0, 8'h54, 32'h0, TMO + 4, 1'b0, 32'h5555_AAAA, 1'b0);
`endif
        for (int k = 0; k < 40; k++) begin
            do_txn(1'($urandom), 2'($urandom_range(0, 3)), 8'($urandom), $urandom,
                   int'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0), $urandom, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
